// File: rtl/png_pixel_framer_if.sv
// Pixel stream bundle between hard_png, the framer and the framebuffer writer.
// The input side carries hard_png's ostart/geometry/ovalid/pixel outputs.
// The output side is a valid/ready beat stream with frame markers.
// slave  : the framer's view (consumes the hard_png side, drives the beat stream)
// master : the environment's view (drives hard_png side, consumes the beat stream)
interface png_pixel_framer_if;
  logic        istart;
  logic [2:0]  icolortype;
  logic [13:0] iwidth;
  logic [31:0] iheight;
  logic        ivalid;
  logic [31:0] ipixel;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;

  modport slave (
    input  istart, icolortype, iwidth, iheight, ivalid, ipixel,
    input  m_ready,
    output m_valid, m_data, m_sof, m_eol, m_eof
  );

  modport master (
    output istart, icolortype, iwidth, iheight, ivalid, ipixel,
    output m_ready,
    input  m_valid, m_data, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/png_pixel_framer.sv
// png_pixel_framer: tags hard_png pixels with sof/eol/eof and buffers them in
// an elastic FIFO feeding a valid/ready stream. hard_png cannot be stalled, so
// pixels arriving at a full FIFO are dropped and counted; the x/y counters keep
// advancing so frame geometry of later pixels stays correct.
//
//  state  | meaning
//  IDLE   | no image since reset; ivalid is unexpected
//  RUN    | image in progress, pixels are tagged and queued
//  DONE   | last pixel seen (or empty geometry); ivalid is unexpected
module png_pixel_framer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  png_pixel_framer_if.slave bus,
  output logic [2:0]       colortype,
  output logic [13:0]      width,
  output logic [31:0]      height,
  output logic             busy,
  output logic             overflow,
  output logic             excess,
  output logic             abort,
  output logic [15:0]      drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 35;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]  r_colortype;
  logic [13:0] r_width;
  logic [31:0] r_height;
  logic [13:0] r_x;
  logic [31:0] r_y;

  logic        r_overflow;
  logic        r_excess;
  logic        r_abort;
  logic [15:0] r_drop_cnt;

  logic [ENTRY_W-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_pix_in;
  logic               w_push;
  logic               w_drop;
  logic               w_sof;
  logic               w_eol;
  logic               w_eof;
  logic               w_geom_zero;
  logic [ENTRY_W-1:0] w_head;

  // FIFO status: extra pointer MSB distinguishes full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign w_pop   = !w_empty && bus.m_ready;

  // A pixel is only framed in RUN; a coincident istart wins over ivalid.
  assign w_pix_in = (r_state == S_RUN) && bus.ivalid && !bus.istart;

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign w_push = w_pix_in && (!w_full || w_pop);
  assign w_drop = w_pix_in && w_full && !w_pop;

  // Geometry is known nonzero in RUN, so width-1/height-1 cannot underflow here.
  assign w_sof = (r_x == 14'd0) && (r_y == 32'd0);
  assign w_eol = (r_x == (r_width - 14'd1));
  assign w_eof = w_eol && (r_y == (r_height - 32'd1));

  assign w_geom_zero = (bus.iwidth == 14'd0) || (bus.iheight == 32'd0);

  // Head entry is gated so an empty FIFO presents all-zero beat fields.
  assign w_head       = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign bus.m_valid  = !w_empty;
  assign bus.m_data   = w_empty ? 32'd0 : w_head[31:0];
  assign bus.m_sof    = !w_empty && w_head[34];
  assign bus.m_eol    = !w_empty && w_head[33];
  assign bus.m_eof    = !w_empty && w_head[32];

  assign colortype = r_colortype;
  assign width     = r_width;
  assign height    = r_height;
  assign busy      = (r_state == S_RUN);
  assign overflow  = r_overflow;
  assign excess    = r_excess;
  assign abort     = r_abort;
  assign drop_cnt  = r_drop_cnt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: istart restarts from any state; eof pixel finishes the image
  always_comb begin
    w_state_nxt = r_state;
    if (bus.istart) begin
      w_state_nxt = w_geom_zero ? S_DONE : S_RUN;
    end else if (w_pix_in && w_eof) begin
      w_state_nxt = S_DONE;
    end
  end

  // Geometry latch on istart
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_colortype <= 3'd0;
      r_width     <= 14'd0;
      r_height    <= 32'd0;
    end else if (bus.istart) begin
      r_colortype <= bus.icolortype;
      r_width     <= bus.iwidth;
      r_height    <= bus.iheight;
    end
  end

  // Pixel position: advances for every framed pixel, stored or dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= 14'd0;
      r_y <= 32'd0;
    end else if (bus.istart) begin
      r_x <= 14'd0;
      r_y <= 32'd0;
    end else if (w_pix_in) begin
      if (w_eol) begin
        r_x <= 14'd0;
        r_y <= r_y + 32'd1;
      end else begin
        r_x <= r_x + 14'd1;
      end
    end
  end

  // Per-frame status flags and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_excess   <= 1'b0;
      r_abort    <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else begin
      r_abort <= bus.istart && (r_state == S_RUN);
      if (bus.istart) begin
        r_overflow <= 1'b0;
        r_excess   <= 1'b0;
        r_drop_cnt <= 16'd0;
      end else begin
        if (bus.ivalid && (r_state != S_RUN)) begin
          r_excess <= 1'b1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != 16'hFFFF) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
        end
      end
    end
  end

  // FIFO pointers; istart flushes so the next cycle shows an empty FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (bus.istart) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // FIFO storage: {sof, eol, eof, rgba}; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[DEPTH_LOG2-1:0]] <= {w_sof, w_eol, w_eof, bus.ipixel};
    end
  end

endmodule

// File: tb/tb_png_pixel_framer.sv
// Testbench for png_pixel_framer: directed scenarios plus randomized frames,
// checked cycle by cycle against a queue-based reference of the framer.
module tb_png_pixel_framer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  png_pixel_framer_if bus ();

  logic [2:0]  colortype;
  logic [13:0] width;
  logic [31:0] height;
  logic        busy, overflow, excess, abort;
  logic [15:0] drop_cnt;

  png_pixel_framer #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .colortype (colortype),
    .width     (width),
    .height    (height),
    .busy      (busy),
    .overflow  (overflow),
    .excess    (excess),
    .abort     (abort),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  // reference model: pixel index n within frame, queue as the FIFO
  beat_t   q[$];
  bit      run_m;
  longint  n_m, w_m, h_m;
  bit [2:0] ct_m;
  bit      ovf_m, exc_m, abort_m;
  int      drop_m;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    run_m = 0; n_m = 0; w_m = 0; h_m = 0; ct_m = 3'd0;
    ovf_m = 0; exc_m = 0; abort_m = 0; drop_m = 0;
  endtask

  task automatic compare_all();
    chk("m_valid", 64'(bus.m_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_data", 64'(bus.m_data), 64'(q[0].d));
      chk("m_sof", 64'(bus.m_sof), 64'(q[0].sof));
      chk("m_eol", 64'(bus.m_eol), 64'(q[0].eol));
      chk("m_eof", 64'(bus.m_eof), 64'(q[0].eof));
    end
    chk("busy", 64'(busy), 64'(run_m));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("excess", 64'(excess), 64'(exc_m));
    chk("abort", 64'(abort), 64'(abort_m));
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    chk("width", 64'(width), 64'(w_m));
    chk("height", 64'(height), 64'(h_m));
    chk("colortype", 64'(colortype), 64'(ct_m));
  endtask

  task automatic do_cycle(bit ist, bit [13:0] w, bit [31:0] h, bit [2:0] ct,
                          bit iv, bit rdy);
    logic [31:0] pix;
    beat_t b;
    pix = $urandom;
    bus.istart     = ist;
    bus.iwidth     = w;
    bus.iheight    = h;
    bus.icolortype = ct;
    bus.ivalid     = iv;
    bus.ipixel     = pix;
    bus.m_ready    = rdy;
    @(posedge clk);
    if (ist) begin
      abort_m = run_m;
      q.delete();
      w_m = longint'(w); h_m = longint'(h); ct_m = ct;
      n_m = 0; ovf_m = 0; exc_m = 0; drop_m = 0;
      run_m = (w != 0) && (h != 0);
    end else begin
      abort_m = 0;
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (iv) begin
        if (run_m) begin
          b.d   = pix;
          b.sof = (n_m == 0);
          b.eol = ((n_m % w_m) == w_m - 1);
          b.eof = (n_m == w_m * h_m - 1);
          if (q.size() < 16) q.push_back(b);
          else begin
            ovf_m = 1;
            if (drop_m < 65535) drop_m++;
          end
          n_m++;
          if (b.eof) run_m = 0;
        end else begin
          exc_m = 1;
        end
      end
    end
    #1;
    compare_all();
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) do_cycle(0, 14'd0, 32'd0, 3'd0, 0, rdy);
  endtask

  task automatic pixels(int n, bit rdy);
    for (int i = 0; i < n; i++) do_cycle(0, 14'd0, 32'd0, 3'd0, 1, rdy);
  endtask

  initial begin
    int fw, fh;
    rst = 1'b1;
    bus.istart = 0; bus.iwidth = 0; bus.iheight = 0; bus.icolortype = 0;
    bus.ivalid = 0; bus.ipixel = 0; bus.m_ready = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 3x2 image, downstream always ready
    do_cycle(1, 14'd3, 32'd2, 3'd6, 0, 1);
    pixels(6, 1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    idle(2, 1);

    // 20x1 image into a stalled sink: 16 stored, 4 dropped, eof lost
    do_cycle(1, 14'd20, 32'd1, 3'd2, 0, 0);
    pixels(20, 0);
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("t2_overflow", 64'(overflow), 64'd1);
    idle(18, 1);

    // full FIFO with simultaneous pop accepts the push
    do_cycle(1, 14'd20, 32'd1, 3'd2, 0, 0);
    pixels(16, 0);
    pixels(1, 1);
    chk("t3_no_drop", 64'(drop_cnt), 64'd0);
    idle(18, 1);

    // restart mid-frame: abort pulse, flush, new sof
    do_cycle(1, 14'd4, 32'd4, 3'd6, 0, 0);
    pixels(3, 0);
    do_cycle(1, 14'd4, 32'd4, 3'd6, 0, 0);
    chk("t4_abort", 64'(abort), 64'd1);
    chk("t4_flushed", 64'(bus.m_valid), 64'd0);
    pixels(2, 0);
    chk("t4_new_sof", 64'(bus.m_sof), 64'd1);
    idle(1, 0);
    chk("t4_abort_gone", 64'(abort), 64'd0);
    idle(3, 1);

    // zero width: straight to done, stray pixel raises excess
    do_cycle(1, 14'd0, 32'd5, 3'd0, 0, 1);
    chk("t5_busy", 64'(busy), 64'd0);
    pixels(1, 1);
    chk("t5_excess", 64'(excess), 64'd1);
    idle(1, 1);

    // asynchronous reset with beats queued
    do_cycle(1, 14'd4, 32'd4, 3'd6, 0, 0);
    pixels(5, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t6_valid", 64'(bus.m_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    bus.ivalid = 0; bus.istart = 0;
    @(posedge clk);
    #1;
    compare_all();

    // randomized frames with random ivalid gaps and sink stalls
    for (int f = 0; f < 8; f++) begin
      fw = $urandom_range(1, 6);
      fh = $urandom_range(1, 4);
      do_cycle(1, 14'(fw), 32'(fh), 3'($urandom_range(0, 7)), 0,
               1'($urandom_range(0, 1)));
      for (int c = 0; c < fw * fh * 4 + 10; c++) begin
        do_cycle(0, 14'd0, 32'd0, 3'd0, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6));
      end
      idle(20, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
